adder_top: RTL and testbench



---
 rtl/adder_pkg.sv | 17 +
 rtl/full_adder.sv | 17 +
 rtl/adder_top.sv | 72 +++++++
 tb/tb_adder_top.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and reference model for the ripple-carry adder
`timescale 1ns/1ps
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 8;
    localparam int REF_MAX_WIDTH       = 64;

    // Behavioural golden sum; callers take bits [WIDTH:0] for their own width.
    function automatic logic [REF_MAX_WIDTH:0] ref_add(
        input logic [REF_MAX_WIDTH-1:0] a,
        input logic [REF_MAX_WIDTH-1:0] b,
        input logic                     cin
    );
        return {1'b0, a} + {1'b0, b} + {{REF_MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
`timescale 1ns/1ps
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder_top.sv
// rtl/adder_top.sv - ripple-carry adder from full-adder cells with optional output register
`timescale 1ns/1ps
module adder_top
    import adder_pkg::*;
#(
    parameter int WIDTH   = ADDER_DEFAULT_WIDTH,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] sum_c;
    logic             carry_c;

    // Each stage owns its own carry nets so the chain is not one self-dependent vector.
    for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
        logic ci_w;
        logic co_w;

        if (i == 0) begin : g_first
            assign ci_w = cin;
        end else begin : g_rest
            assign ci_w = gen_fa[i-1].co_w;
        end

        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (ci_w),
            .s  (sum_c[i]),
            .co (co_w)
        );
    end

    assign carry_c = gen_fa[WIDTH-1].co_w;

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] s_d, s_q;
        logic             cout_d, cout_q;

        always_comb begin
            s_d    = sum_c;
            cout_d = carry_c;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q    <= '0;
                cout_q <= 1'b0;
            end else begin
                s_q    <= s_d;
                cout_q <= cout_d;
            end
        end

        assign s    = s_q;
        assign cout = cout_q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rst_n;
        assign s              = sum_c;
        assign cout           = carry_c;
    end

endmodule

// File: tb/tb_adder_top.sv
// tb/tb_adder_top.sv - directed and exhaustive self-checking bench for adder_top
`timescale 1ns/1ps
module tb_adder_top;
    import adder_pkg::*;

    logic       clk;
    logic       rst_n;

    logic [7:0] a_c, b_c, s_c;
    logic       cin_c, cout_c;
    logic [7:0] a_r, b_r, s_r;
    logic       cin_r, cout_r;
    logic [3:0] a_4, b_4, s_4;
    logic       cin_4, cout_4;

    int checks;
    int errors;

    adder_top #(.WIDTH(8), .REG_OUT(1'b0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .a(a_c), .b(b_c), .cin(cin_c), .s(s_c), .cout(cout_c)
    );

    adder_top #(.WIDTH(8), .REG_OUT(1'b1)) dut_reg (
        .clk(clk), .rst_n(rst_n), .a(a_r), .b(b_r), .cin(cin_r), .s(s_r), .cout(cout_r)
    );

    adder_top #(.WIDTH(4), .REG_OUT(1'b0)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .a(a_4), .b(b_4), .cin(cin_4), .s(s_4), .cout(cout_4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_reg(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clk);
        a_r   = a;
        b_r   = b;
        cin_r = cin;
    endtask

    initial begin
        logic [REF_MAX_WIDTH:0] r;
        logic [8:0]             exp9;
        logic [4:0]             exp5;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_c = '0; b_c = '0; cin_c = 1'b0;
        a_r = 8'h10; b_r = 8'h20; cin_r = 1'b1;
        a_4 = '0; b_4 = '0; cin_4 = 1'b0;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
        vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        // Reset state of the registered adder while rst_n is held low across edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset_s", 32'(s_r), 32'h00);
        check("reset_cout", 32'(cout_r), 32'h0);

        for (int i = 0; i < 8; i++) begin
            a_c = vecs[i].a; b_c = vecs[i].b; cin_c = vecs[i].cin;
            #4;
            check($sformatf("vec%0d_s", i), 32'(s_c), 32'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 32'(cout_c), 32'(vecs[i].cout));
            #1;
        end

        for (int ci = 0; ci < 2; ci++) begin
            for (int ai = 0; ai < 256; ai++) begin
                for (int bi = 0; bi < 256; bi++) begin
                    a_c = 8'(ai); b_c = 8'(bi); cin_c = 1'(ci);
                    #4;
                    r    = ref_add(64'(ai), 64'(bi), 1'(ci));
                    exp9 = r[8:0];
                    check($sformatf("sweep8 a=%0h b=%0h cin=%0d", ai, bi, ci),
                          32'({cout_c, s_c}), 32'(exp9));
                    #1;
                end
            end
        end

        a_4 = 4'hF; b_4 = 4'h1; cin_4 = 1'b0;
        #4;
        check("w4_wrap_s", 32'(s_4), 32'h0);
        check("w4_wrap_cout", 32'(cout_4), 32'h1);
        #1;
        for (int ci = 0; ci < 2; ci++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    a_4 = 4'(ai); b_4 = 4'(bi); cin_4 = 1'(ci);
                    #4;
                    r    = ref_add(64'(ai), 64'(bi), 1'(ci));
                    exp5 = r[4:0];
                    check($sformatf("sweep4 a=%0h b=%0h cin=%0d", ai, bi, ci),
                          32'({cout_4, s_4}), 32'(exp5));
                    #1;
                end
            end
        end

        // Registered mode: one-cycle latency, new result every edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive_reg(8'h10, 8'h20, 1'b1);
        @(posedge clk); #1;
        check("reg_n_s", 32'(s_r), 32'h31);
        check("reg_n_cout", 32'(cout_r), 32'h0);
        drive_reg(8'h80, 8'h80, 1'b0);
        @(posedge clk); #1;
        check("reg_n1_s", 32'(s_r), 32'h00);
        check("reg_n1_cout", 32'(cout_r), 32'h1);
        drive_reg(8'h10, 8'h20, 1'b1);
        @(posedge clk); #1;
        check("reg_hold_s", 32'(s_r), 32'h31);

        // Async reset mid-cycle clears outputs without a clock edge.
        #4;
        rst_n = 1'b0;
        #1;
        check("async_rst_s", 32'(s_r), 32'h00);
        check("async_rst_cout", 32'(cout_r), 32'h0);
        a_r = 8'hFF; b_r = 8'h01; cin_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_hold%0d", k), 32'({cout_r, s_r}), 32'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_pre_edge", 32'({cout_r, s_r}), 32'h000);
        @(posedge clk); #1;
        check("rst_release_first_s", 32'(s_r), 32'h01);
        check("rst_release_first_cout", 32'(cout_r), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
